// File: rtl/ldo_trim_pkg.sv
// Shared definitions for the LDO trim sequencer.
// Holds the Wishbone register word offsets, the CTRL/STATUS bit positions,
// the sequencer state type and the index-to-one-hot helper.
package ldo_trim_pkg;

  // Register word offsets (byte address bits [7:2]).
  localparam logic [5:0] WORD_CTRL    = 6'd0;
  localparam logic [5:0] WORD_STATUS  = 6'd1;
  localparam logic [5:0] WORD_TARGET0 = 6'd2;  // CUR_0 follows the NUM_CH targets

  // CTRL / STATUS bit positions.
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_STEP_DIV_LSB = 16;
  localparam int STATUS_DONE_BIT   = 8;

  // Widest trim bus the helper below can encode.
  localparam int ONEHOT_MAX_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // One-hot vector with bit idx set; callers cast down to their trim width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_idx(input int unsigned idx);
    logic [ONEHOT_MAX_W-1:0] one;
    one = ONEHOT_MAX_W'(1);
    return one << idx;
  endfunction

endpackage

// File: rtl/ldo_trim_chan.sv
// One LDO trim channel: target and current index registers, a one-position
// up/down stepper and the registered one-hot trim encoder.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tick           step enable from the shared divider
//   tgt_we         target write strobe, tgt_wdata the new target index
//   tgt, cur       target and current index (register readback)
//   busy           registered cur != tgt
//   busy_nxt       value busy takes on the next edge (lets the sequencer
//                  finish on the same edge as the last step)
//   trim           registered one-hot of cur
module ldo_trim_chan
  import ldo_trim_pkg::*;
#(
  parameter int TRIM_W    = 16,
  parameter int IDX_W     = 4,
  parameter int RESET_IDX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              tgt_we,
  input  logic [IDX_W-1:0]  tgt_wdata,
  output logic [IDX_W-1:0]  tgt,
  output logic [IDX_W-1:0]  cur,
  output logic              busy,
  output logic              busy_nxt,
  output logic [TRIM_W-1:0] trim
);

  localparam logic [IDX_W-1:0]  IDX_RST  = IDX_W'(RESET_IDX);
  localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'(onehot_idx(RESET_IDX));

  logic [IDX_W-1:0]  tgt_d;
  logic [IDX_W-1:0]  cur_d;
  logic [TRIM_W-1:0] trim_d;

  // The step direction uses the registered target, so a retarget acked
  // mid-interval is seen at the next tick.
  always_comb begin
    tgt_d = tgt_we ? tgt_wdata : tgt;
    cur_d = cur;
    if (tick && busy) begin
      if (tgt > cur) cur_d = cur + IDX_W'(1);
      else           cur_d = cur - IDX_W'(1);
    end
    busy_nxt = (cur_d != tgt_d);
    trim_d   = TRIM_W'(onehot_idx(32'(cur_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt  <= IDX_RST;
      cur  <= IDX_RST;
      busy <= 1'b0;
      trim <= TRIM_RST;
    end else begin
      tgt  <= tgt_d;
      cur  <= cur_d;
      busy <= busy_nxt;
      trim <= trim_d;
    end
  end

endmodule

// File: rtl/ldo_trim_ctrl.sv
// Wishbone-programmable trim sequencer for the fullldom LDO instances.
// Each channel ramps its one-hot trim one position per (step_div + 1) cycles
// toward a software target; done/irq flag the end of a complete ramp.
// Ports:
//   wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//   wbs_*                  Wishbone classic slave (adr[7:2] decoded)
//   trim_o                 one-hot trim, channel c at [c*TRIM_W +: TRIM_W]
//   busy_o                 per-channel cur != target
//   irq_o                  level interrupt, done & irq_en
//   seq_state_o            sequencer state (debug observation)
//
// Handshake: a request is taken on an edge where cyc & stb & !ack; ack is
// high for exactly the following cycle and the write / read data update on
// that same edge. While ack is high no new request is taken, so ack is
// always low for at least one cycle between transfers.
module ldo_trim_ctrl
  import ldo_trim_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int TRIM_W    = 16,
  parameter int RESET_IDX = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_CH*TRIM_W-1:0] trim_o,
  output logic [NUM_CH-1:0]        busy_o,
  output logic                     irq_o,
  output seq_state_t               seq_state_o
);

  localparam int         IDX_W     = $clog2(TRIM_W);
  localparam logic [5:0] WORD_CUR0 = WORD_TARGET0 + 6'(NUM_CH);

  logic              ack_q;
  logic [31:0]       dat_q;
  logic              enable_q, irq_en_q, done_q, irq_q;
  logic              enable_d, irq_en_d, done_d, done_set;
  logic [15:0]       step_div_q, step_div_d;
  logic [15:0]       cnt_q, cnt_d;
  seq_state_t        state_q, state_d;
  logic              tick;
  logic              wb_req, wb_wr;
  logic [5:0]        word;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] busy, busy_nxt, tgt_we;
  logic [IDX_W-1:0]  tgt [NUM_CH];
  logic [IDX_W-1:0]  cur [NUM_CH];
  logic              unused_bits;

  assign wb_req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wb_wr       = wb_req & wbs_we_i;
  assign word        = wbs_adr_i[7:2];
  assign unused_bits = ^{wbs_adr_i, wbs_dat_i};

  // CTRL write with byte-lane enables.
  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    step_div_d = step_div_q;
    if (wb_wr && word == WORD_CTRL) begin
      if (wbs_sel_i[0]) begin
        enable_d = wbs_dat_i[CTRL_ENABLE_BIT];
        irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
      end
      if (wbs_sel_i[2]) step_div_d[7:0]  = wbs_dat_i[CTRL_STEP_DIV_LSB +: 8];
      if (wbs_sel_i[3]) step_div_d[15:8] = wbs_dat_i[CTRL_STEP_DIV_LSB+8 +: 8];
    end
  end

  // done: W1C from software, but a completion in the same cycle wins.
  always_comb begin
    done_d = done_q;
    if (wb_wr && word == WORD_STATUS && wbs_sel_i[1] && wbs_dat_i[STATUS_DONE_BIT])
      done_d = 1'b0;
    if (done_set)
      done_d = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      tgt_we[c] = wb_wr && wbs_sel_i[0] && (word == WORD_TARGET0 + 6'(c));
  end

  // Read mux; unmapped words read zero.
  always_comb begin
    rdata = '0;
    if (word == WORD_CTRL) begin
      rdata[CTRL_STEP_DIV_LSB +: 16] = step_div_q;
      rdata[CTRL_IRQ_EN_BIT]         = irq_en_q;
      rdata[CTRL_ENABLE_BIT]         = enable_q;
    end else if (word == WORD_STATUS) begin
      rdata[NUM_CH-1:0]      = busy;
      rdata[STATUS_DONE_BIT] = done_q;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (word == WORD_TARGET0 + 6'(c)) rdata[IDX_W-1:0] = tgt[c];
      if (word == WORD_CUR0 + 6'(c))    rdata[IDX_W-1:0] = cur[c];
    end
  end

  // >= rather than == so lowering step_div below the running count
  // fires at once instead of wrapping the 16-bit counter.
  assign tick = (state_q == RUN) && enable_q && (cnt_q >= step_div_q);

  // Sequencer. Completion is judged on busy_nxt so that done, irq and the
  // return to IDLE land on the same edge as the final step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && (|busy)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!enable_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (tick) cnt_d = '0;
          else      cnt_d = cnt_q + 16'd1;
          if (!(|busy_nxt)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      step_div_q <= '0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
    end else begin
      ack_q      <= wb_req;
      if (wb_req) dat_q <= rdata;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      step_div_q <= step_div_d;
      done_q     <= done_d;
      irq_q      <= done_d & irq_en_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ldo_trim_chan #(
      .TRIM_W    (TRIM_W),
      .IDX_W     (IDX_W),
      .RESET_IDX (RESET_IDX)
    ) u_chan (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .tick      (tick),
      .tgt_we    (tgt_we[c]),
      .tgt_wdata (wbs_dat_i[IDX_W-1:0]),
      .tgt       (tgt[c]),
      .cur       (cur[c]),
      .busy      (busy[c]),
      .busy_nxt  (busy_nxt[c]),
      .trim      (trim_o[c*TRIM_W +: TRIM_W])
    );
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign busy_o      = busy;
  assign irq_o       = irq_q;
  assign seq_state_o = state_q;

endmodule

// File: tb/tb_ldo_trim_ctrl.sv
module tb_ldo_trim_ctrl;
  import ldo_trim_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_TGT0   = 32'h08;
  localparam logic [31:0] A_TGT1   = 32'h0C;
  localparam logic [31:0] A_TGT2   = 32'h10;
  localparam logic [31:0] A_CUR0   = 32'h14;
  localparam logic [31:0] A_UNMAP  = 32'h40;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack;
  logic [47:0] trim;
  logic [2:0]  busy;
  logic        irq;
  seq_state_t  seq_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: bit 32 marks a read whose data must be compared.
  logic [32:0] wb_exp_q[$];
  logic [47:0] trim_exp_q[$];
  int          model_idx[3] = '{8, 8, 8};
  logic        prev_ack  = 1'b0;
  logic [47:0] prev_trim = {3{16'h0100}};

  ldo_trim_ctrl #(.NUM_CH(3), .TRIM_W(16), .RESET_IDX(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .trim_o      (trim),
    .busy_o      (busy),
    .irq_o       (irq),
    .seq_state_o (seq_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [47:0] model_vec();
    logic [47:0] v;
    logic [15:0] one;
    one = 16'h0001;
    for (int c = 0; c < 3; c++) v[c*16 +: 16] = one << model_idx[c];
    return v;
  endfunction

  // Push every intermediate one-hot vector of a ramp on channel ch.
  task automatic push_ramp(input int ch, input int to);
    while (model_idx[ch] != to) begin
      model_idx[ch] += (to > model_idx[ch]) ? 1 : -1;
      trim_exp_q.push_back(model_vec());
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy != 3'b000; i++) edges(1);
    check(name, 64'(busy), 64'h0);
  endtask

  // ---------------- driver ----------------
  task automatic wb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_rd);
    logic got;
    wb_exp_q.push_back({~wr, exp_rd});
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wb_timeout adr=0x%0h actual=no_ack expected=ack", a);
      void'(wb_exp_q.pop_back());
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d, 4'hF, 32'h0);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
    wb_xfer(1'b0, a, 32'h0, 4'hF, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [47:0] t;
    if (ack) begin
      check("ack_single_cycle", 64'(prev_ack), 64'h0);
      if (wb_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ack_unexpected actual=ack expected=none");
      end else begin
        e = wb_exp_q.pop_front();
        if (e[32]) check("rd_data", 64'(rdat), 64'(e[31:0]));
      end
    end
    prev_ack = ack;
    if (trim !== prev_trim) begin
      if (trim_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trim_unexpected actual=0x%0h expected=no_change", trim);
      end else begin
        t = trim_exp_q.pop_front();
        check("trim_seq", 64'(trim), 64'(t));
      end
      prev_trim = trim;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    rst_n = 1'b0;
    edges(3);

    // Reset state
    check("rst_trim", 64'(trim), 64'({3{16'h0100}}));
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_state", 64'(seq_state), 64'(IDLE));
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_dat", 64'(rdat), 64'h0);
    rst_n = 1'b1;
    edges(1);
    wb_read(A_CUR0, 32'd8);
    wb_read(A_CTRL, 32'h0);
    wb_read(A_STATUS, 32'h0);
    wb_read(A_TGT2, 32'd8);

    // Ramp 8 -> 12 with step_div = 3: first step 5 cycles after ack, then every 4
    wb_write(A_CTRL, 32'h0003_0003);
    wb_write(A_TGT0, 32'd12);
    push_ramp(0, 12);
    edges(4);
    check("t2_before_first", 64'(trim[15:0]), 64'h0100);
    check("t2_busy", 64'(busy), 64'h1);
    edges(1);
    check("t2_step1", 64'(trim[15:0]), 64'h0200);
    edges(4);
    check("t2_step2", 64'(trim[15:0]), 64'h0400);
    edges(4);
    check("t2_step3", 64'(trim[15:0]), 64'h0800);
    check("t2_irq_pre", 64'(irq), 64'h0);
    edges(4);
    check("t2_step4", 64'(trim[15:0]), 64'h1000);
    check("t2_busy_clear", 64'(busy), 64'h0);
    check("t2_irq", 64'(irq), 64'h1);
    check("t2_state", 64'(seq_state), 64'(IDLE));
    wb_read(A_STATUS, 32'h0000_0100);
    wb_read(A_CUR0, 32'd12);

    // Back to 8, then up toward 15 and retarget to 5 at cur = 10
    wb_write(A_TGT0, 32'd8);
    push_ramp(0, 8);
    wait_idle("t3_down_idle");
    wb_write(A_TGT0, 32'd15);
    push_ramp(0, 10);
    edges(9);
    check("t3_at10", 64'(trim[15:0]), 64'h0400);
    wb_write(A_TGT0, 32'd5);
    push_ramp(0, 5);
    edges(2);
    check("t3_hold", 64'(trim[15:0]), 64'h0400);
    edges(1);
    check("t3_reverse", 64'(trim[15:0]), 64'h0200);
    wait_idle("t3_idle");
    check("t3_final", 64'(trim[15:0]), 64'h0020);
    check("t3_irq_set", 64'(irq), 64'h1);
    wb_read(A_CUR0, 32'd5);
    wb_read(A_TGT0, 32'd5);
    wb_write(A_STATUS, 32'h0000_0100);
    check("t3_irq_clear", 64'(irq), 64'h0);
    wb_read(A_STATUS, 32'h0);

    // Disabled: target pending but no stepping and no done
    wb_write(A_CTRL, 32'h0003_0002);
    wb_write(A_TGT1, 32'd15);
    edges(10);
    check("t4_busy", 64'(busy), 64'h2);
    check("t4_trim_hold", 64'(trim), 64'(model_vec()));
    check("t4_state", 64'(seq_state), 64'(IDLE));
    check("t4_irq", 64'(irq), 64'h0);
    wb_read(A_STATUS, 32'h0000_0002);
    wb_write(A_CTRL, 32'h0003_0003);
    push_ramp(1, 15);
    wait_idle("t4_idle");
    check("t4_final", 64'(trim[31:16]), 64'h8000);
    check("t4_irq", 64'(irq), 64'h1);
    wb_read(A_STATUS, 32'h0000_0100);

    // Asynchronous reset in the middle of a ramp on channel 2
    wb_write(A_STATUS, 32'h0000_0100);
    wb_write(A_TGT2, 32'd0);
    push_ramp(2, 6);
    edges(10);
    check("t5_mid", 64'(trim[47:32]), 64'h0040);
    check("t5_state_run", 64'(seq_state), 64'(RUN));
    model_idx = '{8, 8, 8};
    trim_exp_q.push_back(model_vec());
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_trim", 64'(trim), 64'({3{16'h0100}}));
    check("t5_async_state", 64'(seq_state), 64'(IDLE));
    check("t5_async_busy", 64'(busy), 64'h0);
    check("t5_async_irq", 64'(irq), 64'h0);
    edges(2);
    rst_n = 1'b1;
    edges(1);

    // Byte lanes and unmapped addresses
    wb_xfer(1'b1, A_CTRL, 32'hFFFF_FFFF, 4'b1100, 32'h0);
    wb_read(A_CTRL, 32'hFFFF_0000);
    wb_read(A_UNMAP, 32'h0);
    wb_write(A_UNMAP, 32'hFFFF_FFFF);
    wb_read(A_UNMAP, 32'h0);
    wb_read(32'h3C, 32'h0);
    check("t6_busy", 64'(busy), 64'h0);

    // step_div = 0, target equal to cur
    wb_write(A_CTRL, 32'h0000_0001);
    wb_write(A_TGT1, 32'd8);
    edges(3);
    check("t7_equal_busy", 64'(busy), 64'h0);
    check("t7_equal_state", 64'(seq_state), 64'(IDLE));
    wb_read(A_STATUS, 32'h0);
    wb_write(A_TGT0, 32'd10);
    push_ramp(0, 10);
    edges(1);
    check("t7_step0", 64'(trim[15:0]), 64'h0100);
    edges(1);
    check("t7_step1", 64'(trim[15:0]), 64'h0200);
    edges(1);
    check("t7_step2", 64'(trim[15:0]), 64'h0400);
    check("t7_busy", 64'(busy), 64'h0);
    check("t7_irq_masked", 64'(irq), 64'h0);
    wb_read(A_STATUS, 32'h0000_0100);

    edges(5);
    check("trim_q_drained", 64'(trim_exp_q.size()), 64'h0);
    check("wb_q_drained", 64'(wb_exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
